// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg: shared definitions for the interrupt controller.
//   state_e       - controller FSM state encoding (also exposed on dbg_state)
//   REG_*         - register select values presented on Addr[3:2]
//   HANDLER_ADDR  - fetch redirect target used when PcSel is asserted
//   IRQ_LO/IRQ_HI - range of device interrupt line numbers (2..7)
package int_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ENTER   = 2'd1,
    ST_SERVICE = 2'd2,
    ST_EXIT    = 2'd3
  } state_e;

  localparam logic [1:0]  REG_PEND     = 2'd0;
  localparam logic [1:0]  REG_MASK     = 2'd1;
  localparam logic [1:0]  REG_ACTIVE   = 2'd2;

  localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

  localparam int IRQ_LO = 2;
  localparam int IRQ_HI = 7;
  localparam int IRQ_W  = IRQ_HI - IRQ_LO + 1;

endpackage

// File: rtl/int_ctrl_prio_enc6.sv
// prio_enc6: 6-input highest-first priority encoder.
//   req   - request vector, req[0] is line IRQ_LO, req[5] is line IRQ_HI
//   idx   - line number of the highest set request, encoded IRQ_LO..IRQ_HI
//   valid - at least one request is set (idx is 0 otherwise)
module prio_enc6
  import int_ctrl_pkg::*;
(
  input  logic [IRQ_W-1:0] req,
  output logic [2:0]       idx,
  output logic             valid
);

  // Scan upward so the highest set bit is the last one to win.
  always_comb begin
    idx   = 3'd0;
    valid = 1'b0;
    for (int i = 0; i < IRQ_W; i++) begin
      if (req[i]) begin
        idx   = 3'(i + IRQ_LO);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: interrupt controller between devices, the data bus and cp0.
//   clk, rst            - clock, asynchronous active-high reset
//   DevReq[7:2]         - device lines; a rising edge sets the PEND bit
//   We, Addr, WData     - bus write port (PEND is W1C, MASK is R/W,
//                         ACTIVE is read-only)
//   RData               - combinational read of the selected register
//   HWInt[7:2]          - registered PEND & MASK toward cp0
//   IntReq, InstrValid  - cp0 request and "instruction is interruptible"
//   Eret, MtcWen        - eret commit, software mtc0 write enable
//   Cp0Wen, EXLSet, EXLClr, Flush, PcSel - control pulses to cp0/pipeline
//   dbg_state           - current FSM state
//
// Handshake note: there is no valid/ready pair here; all inputs are
// level-sampled on the rising clk edge and every output pulse lasts
// exactly one cycle of the state that produces it.
module int_ctrl
  import int_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:2]  DevReq,
  input  logic        We,
  input  logic [3:2]  Addr,
  input  logic [31:0] WData,
  output logic [31:0] RData,
  output logic [7:2]  HWInt,
  input  logic        IntReq,
  input  logic        InstrValid,
  input  logic        Eret,
  input  logic        MtcWen,
  output logic        Cp0Wen,
  output logic        EXLSet,
  output logic        EXLClr,
  output logic        Flush,
  output logic        PcSel,
  output logic [1:0]  dbg_state
);

  state_e      state_q, state_d;
  logic [7:2]  dev_q, dev_d;
  logic [7:2]  pend_q, pend_d;
  logic [7:2]  mask_q, mask_d;
  logic [7:2]  hw_q, hw_d;
  logic [2:0]  active_q, active_d;

  logic [7:2]  rise;
  logic [7:2]  w1c;
  logic [7:2]  pend_masked;
  logic [2:0]  enc_idx;
  logic        enc_valid;
  logic        in_enter;
  logic        in_exit;

  logic        unused_wdata;
  assign unused_wdata = ^{WData[31:8], WData[1:0]};

  prio_enc6 u_prio_enc6 (
    .req   (pend_masked),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  assign pend_masked = pend_q & mask_q;
  assign in_enter    = (state_q == ST_ENTER);
  assign in_exit     = (state_q == ST_EXIT);

  // Register file and edge detection.
  always_comb begin
    dev_d  = DevReq;
    rise   = DevReq & ~dev_q;
    w1c    = (We && Addr == REG_PEND) ? WData[7:2] : 6'd0;
    // A new edge wins over a same-cycle clear so no event is lost.
    pend_d = (pend_q & ~w1c) | rise;
    mask_d = (We && Addr == REG_MASK) ? WData[7:2] : mask_q;
    hw_d   = pend_masked;

    active_d = active_q;
    if (in_enter) begin
      active_d = enc_valid ? enc_idx : 3'd0;
    end else if (in_exit) begin
      active_d = 3'd0;
    end
  end

  // Next-state logic. Entry is checked before a software eret in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (IntReq && InstrValid) begin
          state_d = ST_ENTER;
        end else if (Eret) begin
          state_d = ST_EXIT;
        end
      end
      ST_ENTER:   state_d = ST_SERVICE;
      ST_SERVICE: if (Eret) state_d = ST_EXIT;
      ST_EXIT:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      dev_q    <= 6'd0;
      pend_q   <= 6'd0;
      mask_q   <= 6'd0;
      hw_q     <= 6'd0;
      active_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      dev_q    <= dev_d;
      pend_q   <= pend_d;
      mask_q   <= mask_d;
      hw_q     <= hw_d;
      active_q <= active_d;
    end
  end

  // Read mux: PEND/MASK keep their bit positions, ACTIVE is a small number.
  always_comb begin
    RData = 32'd0;
    case (Addr)
      REG_PEND:   RData = {24'd0, pend_q, 2'b00};
      REG_MASK:   RData = {24'd0, mask_q, 2'b00};
      REG_ACTIVE: RData = {29'd0, active_q};
      default:    RData = 32'd0;
    endcase
  end

  // Pulses are decoded from the state register, so reset kills them
  // immediately; MtcWen is gated by rst so Cp0Wen is also quiet in reset.
  assign HWInt     = hw_q;
  assign Cp0Wen    = ~rst & (MtcWen | in_enter | in_exit);
  assign EXLSet    = in_enter;
  assign Flush     = in_enter;
  assign PcSel     = in_enter;
  assign EXLClr    = in_exit;
  assign dbg_state = state_q;

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port DevReq, input, [7:2], device interrupt lines; a rising edge sets the matching pending bit.
REQ-004 SHALL have port We, input, 1, register write strobe from the data bus.
REQ-005 SHALL have port Addr, input, [3:2], register select: 0=PEND, 1=MASK, 2=ACTIVE, 3=reserved.
REQ-006 SHALL have port WData, input, [31:0], write data; only bits [7:2] are used.
REQ-007 SHALL have port RData, output, [31:0], combinational read of the selected register, zero-extended; reserved reads 0.
REQ-008 SHALL have port HWInt, output, [7:2], PEND & MASK, registered, to cp0.
REQ-009 SHALL have port IntReq, input, 1, interrupt request from cp0.
REQ-010 SHALL have port InstrValid, input, 1, current instruction is interruptible (not stalled, not in a delay slot).
REQ-011 SHALL have port Eret, input, 1, eret committing this cycle.
REQ-012 SHALL have port MtcWen, input, 1, software mtc0 write enable.
REQ-013 SHALL have port Cp0Wen, output, 1, cp0 write enable = MtcWen | ENTER | EXIT.
REQ-014 SHALL have ports EXLSet and EXLClr, output, 1 each, to cp0.
REQ-015 SHALL have port Flush, output, 1, squash in-flight instructions.
REQ-016 SHALL have port PcSel, output, 1, redirect fetch to handler 0x0000_4180.

Function
REQ-017 PEND bit i SHALL set on DevReq[i] rising edge, detected against a one-cycle delayed copy.
REQ-018 Writing PEND SHALL be write-1-to-clear; set and clear on the same bit in the same cycle SHALL leave it set.
REQ-019 A repeat edge on an already-pending bit SHALL be absorbed; there is no counting.
REQ-020 MASK SHALL be read/write; ACTIVE SHALL be read-only, and bus writes to it SHALL be ignored.
REQ-021 HWInt SHALL equal the previous cycle's PEND & MASK, giving one cycle of latency.
REQ-022 The FSM SHALL have states IDLE, ENTER, SERVICE and EXIT.
REQ-023 IDLE -> ENTER SHALL occur when IntReq & InstrValid; with IntReq high and InstrValid low, the FSM SHALL stay in IDLE.
REQ-024 ENTER SHALL last exactly one cycle, asserting Cp0Wen, EXLSet, Flush and PcSel together.
REQ-025 ENTER SHALL load ACTIVE with the highest-priority bit of PEND & MASK, where bit 7 is highest, encoded 2..7.
REQ-026 ENTER -> SERVICE SHALL be unconditional.
REQ-027 In SERVICE, the FSM SHALL ignore IntReq and wait for Eret.
REQ-028 SERVICE -> EXIT SHALL occur on Eret.
REQ-029 Eret in IDLE SHALL also go to EXIT, covering a software-initiated return.
REQ-030 EXIT SHALL last exactly one cycle, asserting Cp0Wen and EXLClr, clearing ACTIVE to 0, then returning to IDLE.
REQ-031 The EPC overwrite caused by Cp0Wen in EXIT SHALL be acceptable, since the return target is consumed in the Eret cycle.
REQ-032 Eret in ENTER SHALL be ignored.
REQ-033 EXLSet and EXLClr SHALL never be asserted in the same cycle.
REQ-034 PEND SHALL NOT be auto-cleared on entry; the handler clears it via W1C.

Reset
REQ-035 Reset SHALL set state to IDLE and clear PEND, MASK, ACTIVE, HWInt and the edge-detect register.
REQ-036 After reset, Cp0Wen, EXLSet, EXLClr, Flush and PcSel SHALL be 0.
REQ-037 Reset asserted mid-ENTER or mid-EXIT SHALL abort immediately; no partial pulse SHALL follow deassertion.

Structure
REQ-038 A shared package SHALL hold: the state encoding, register offsets PEND/MASK/ACTIVE, handler address 0x0000_4180, and the IRQ range constants 2..7.
REQ-039 A sub-module prio_enc6 SHALL provide the 6-to-3 highest-first priority encoder with a valid flag.

Verification
REQ-040 MASK=0x0C (bits 2,3) then a DevReq[3] edge -> PEND=0x08 next cycle, HWInt[3]=1 one cycle later.
REQ-041 PEND bits 4 and 6 set with MASK=0xFC, IntReq=1, InstrValid=1 -> one-cycle ENTER with EXLSet=Flush=PcSel=Cp0Wen=1, and ACTIVE=6.
REQ-042 IntReq=1 with InstrValid=0 for 3 cycles then 1 -> ENTER occurs exactly in the cycle after InstrValid rises.
REQ-043 In SERVICE, pulse Eret -> one EXIT cycle with EXLClr=1 and Cp0Wen=1; ACTIVE=0 and state IDLE next cycle.
REQ-044 A W1C of 0x10 in the same cycle as a DevReq[4] edge -> PEND[4] remains 1.
REQ-045 Assert rst during ENTER -> all outputs 0 asynchronously, and the FSM is in IDLE when rst falls.
